cla_mp_seq: RTL and testbench
=============================

Name: cla_mp_seq

Overview:
Multi-precision add/subtract sequencer built around one Width-bit cla instance. Accepts Words*Width-bit operands over a valid/ready handshake and feeds one Width-bit slice per cycle through the shared adder, LSW first. Chains the carry between slices through a register and returns the full result and final carry over a second valid/ready handshake. Sits between the execution-unit operand bus and the adder datapath, so that wide arithmetic does not require a Words*Width-bit adder.

Parameters:
Width, 64, bits per adder slice; must be a multiple of 4 (elaboration error otherwise)
Words, 4, number of slices per operation; >= 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  sequencer can accept; high only in IDLE
in_a  input  Words*Width  operand A
in_b  input  Words*Width  operand B
in_ci  input  1  carry-in (add) / borrow-in (sub)
in_sub  input  1  1 = A - B - borrow, 0 = A + B + carry
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  Words*Width  result
out_co  output  1  final carry-out; in sub mode 1 = no borrow
busy  output  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, slice index k=0, carry reg=0, operand/result regs=0. Outputs: out_valid=0, out_sum=0, out_co=0, busy=0, in_ready=1.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_a;
  - latch B as in_sub ? ~in_b : in_b;
  - carry reg = in_sub ? ~in_ci : in_ci;
  - k=0; go to RUN.
- RUN: cla inputs are A slice k, B' slice k, and carry reg.
  - Each edge: write S into out_sum slice k, load carry reg from CO, k=k+1.
  - After slice Words-1: out_co = CO, go to DONE.
  - Exactly Words cycles in RUN.
- DONE: out_valid=1. out_sum and out_co are held stable while out_valid=1. On out_ready: go to IDLE; out_valid drops next cycle.
- Latency: accept at edge E0. out_valid is high after edge E0+Words. Earliest next accept is edge E0+Words+2 (out_ready held high). There is no accept in the same cycle as the output handshake.
- in_valid and operand inputs are ignored outside IDLE. Operands are sampled only on the accept edge, so later input changes have no effect.
- out_ready is ignored unless out_valid=1.
- Words=1: RUN lasts one cycle; behaviour is otherwise identical.
- out_sum slices not yet written during RUN hold their previous values. They are not observable because out_valid=0.
- Reset mid-RUN or mid-DONE: operation is discarded, no out_valid pulse; in_ready=1 after reset deasserts.
- Arithmetic is modulo 2^(Words*Width). out_co is the carry out of the MSB slice.

Decomposition:
- Shared package cla_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - slice-index width constant $clog2(Words) (min 1);
  - elaboration checks for Width%4==0 and Words>=1.
- One sub-module instance: cla #(.Width(Width)) as the shared adder.
- Slice mux/demux and the FSM stay in cla_mp_seq; no further sub-module.

Test Plan:
1. Width=64, Words=4. Add A=0xFFFF_FFFF_FFFF_FFFF, B=1, ci=0 -> out_sum=2^64 (slice1=1, others 0), out_co=0. out_valid rises 4 cycles after the accept edge.
2. Add A=2^256-1, B=0, ci=1 -> out_sum=0, out_co=1; carry ripples through all 4 slices.
3. Sub A=5, B=7, borrow=0 -> out_sum=2^256-2, out_co=0. Then sub A=7, B=5, borrow=0 -> out_sum=2, out_co=1. Then sub A=7, B=5, borrow=1 -> out_sum=1, out_co=1.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid stays 1, out_sum/out_co stable, in_ready=0. A pulsed in_valid with new operands is ignored. Release out_ready -> exactly one handshake, then IDLE.
5. Assert rst during RUN at k=2 -> out_valid never pulses; busy=0 and in_ready=1 immediately. A fresh op afterwards (A=3, B=4) yields 7 with correct latency.
6. Back-to-back ops with in_valid and out_ready held high (1+1, 2+2) -> accepts at edges 0 and 6, results 2 then 4, in order, no drops.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the multi-precision CLA sequencer.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index is never narrower than one bit, even for a single-slice build.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= 4) && ((width % 4) == 0);
  endfunction

  function automatic bit words_ok(input int words);
    return words >= 1;
  endfunction

endpackage

// File: rtl/cla_mp_seq_if.sv
// Operand request and result handshake bundle between the execution unit and the sequencer.
interface cla_mp_seq_if #(
  parameter int Width = 64,
  parameter int Words = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [Words*Width-1:0] in_a;
  logic [Words*Width-1:0] in_b;
  logic                   in_ci;
  logic                   in_sub;
  logic                   out_valid;
  logic                   out_ready;
  logic [Words*Width-1:0] out_sum;
  logic                   out_co;

  modport master (
    output in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_co
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_co
  );

endinterface

// File: rtl/cla.sv
// Width-bit adder built from 4-bit carry-lookahead groups with the group carry passed between groups.
module cla
  import cla_pkg::*;
#(
  parameter int Width = 64
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             ci,
  output logic [Width-1:0] s,
  output logic             co
);

  localparam int Groups = Width / 4;

  if (!width_ok(Width)) begin : g_bad_width
    $error("cla: Width must be a positive multiple of 4");
  end

  logic [Groups:0] gc;

  assign gc[0] = ci;

  for (genvar j = 0; j < Groups; j++) begin : g_grp
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a[4*j +: 4] & b[4*j +: 4];
    assign p = a[4*j +: 4] ^ b[4*j +: 4];

    // Every carry inside the group is expanded directly from the group carry-in.
    assign c[0] = gc[j];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);

    assign gc[j+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c[0]);

    assign s[4*j +: 4] = p ^ c;
  end

  assign co = gc[Groups];

endmodule

// File: rtl/cla_mp_seq.sv
// Feeds Words slices of a wide add/subtract through one shared cla, LSW first, chaining the carry in a register.
module cla_mp_seq
  import cla_pkg::*;
#(
  parameter int Width = 64,
  parameter int Words = 4
) (
  input  logic         clk,
  input  logic         rst,
  cla_mp_seq_if.slave  bus,
  output logic         busy
);

  localparam int KW = idx_width(Words);

  if (!width_ok(Width)) begin : g_bad_width
    $error("cla_mp_seq: Width must be a positive multiple of 4");
  end
  if (!words_ok(Words)) begin : g_bad_words
    $error("cla_mp_seq: Words must be at least 1");
  end

  state_t state, next_state;

  logic [Words-1:0][Width-1:0] a_reg;
  logic [Words-1:0][Width-1:0] b_reg;
  logic [Words-1:0][Width-1:0] sum_reg;
  logic [KW-1:0]               k;
  logic                        carry;
  logic                        co_reg;
  logic                        last;
  logic [Width-1:0]            slice_s;
  logic                        slice_co;

  assign last = (k == KW'(Words - 1));

  cla #(.Width(Width)) u_cla (
    .a  (a_reg[k]),
    .b  (b_reg[k]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid)  next_state = RUN;
      RUN:     if (last)          next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    busy          = (state != IDLE);
  end

  // Subtraction is A + ~B + ~borrow, so B and the borrow are inverted once on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      k       <= '0;
      carry   <= 1'b0;
      co_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.in_a;
            b_reg <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry <= bus.in_sub ? ~bus.in_ci : bus.in_ci;
            k     <= '0;
          end
        end
        RUN: begin
          sum_reg[k] <= slice_s;
          carry      <= slice_co;
          k          <= k + KW'(1);
          if (last) co_reg <= slice_co;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_sum = sum_reg;
  assign bus.out_co  = co_reg;

endmodule

// File: tb/tb_cla_mp_seq.sv
// Directed and random checks of cla_mp_seq against a plain wide-arithmetic reference.
module tb_cla_mp_seq;

  localparam int WIDTH = 64;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  cla_mp_seq_if #(.Width(WIDTH), .Words(WORDS)) bus ();

  cla_mp_seq #(.Width(WIDTH), .Words(WORDS)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result {carry_out, sum}; subtract reports carry_out = 1 when no borrow occurs.
  function automatic logic [N:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic ci, input logic sub);
    logic [N:0] r;
    if (!sub) begin
      r = {1'b0, a} + {1'b0, b} + (N+1)'(ci);
    end else begin
      r    = {1'b0, a} - {1'b0, b} - (N+1)'(ci);
      r[N] = ~r[N];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic ci, input logic sub);
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_ci    = ci;
    bus.in_sub   = sub;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = rand_wide();
    bus.in_b     = rand_wide();
    bus.in_ci    = 1'($urandom);
    bus.in_sub   = 1'($urandom);
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [N:0] exp);
    check({tag, "_valid"}, (N+1)'(bus.out_valid), (N+1)'(1));
    check({tag, "_result"}, {bus.out_co, bus.out_sum}, exp);
  endtask

  task automatic finishHandshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, (N+1)'(bus.out_valid), (N+1)'(0));
    check({tag, "_ready_back"}, (N+1)'(bus.in_ready), (N+1)'(1));
  endtask

  task automatic runOp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci, input logic sub);
    int lat;
    applyStimulus(a, b, ci, sub);
    waitResult(lat);
    check({tag, "_latency"}, (N+1)'(lat), (N+1)'(WORDS));
    checkOutput(tag, ref_op(a, b, ci, sub));
    finishHandshake(tag);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] a, b, all_ones;
    logic [N:0]   exp;
    int           lat;
    int           pulses;
    int           acc_edges[$];
    logic [N:0]   results[$];

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_ci     = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
    all_ones      = '1;
    repeat (2) @(negedge clk);

    check("reset_in_ready", (N+1)'(bus.in_ready), (N+1)'(1));
    check("reset_out_valid", (N+1)'(bus.out_valid), (N+1)'(0));
    check("reset_busy", (N+1)'(busy), (N+1)'(0));
    check("reset_out", {bus.out_co, bus.out_sum}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Carry out of slice 0 lands in slice 1.
    applyStimulus(N'(64'hFFFF_FFFF_FFFF_FFFF), N'(1), 1'b0, 1'b0);
    check("t1_busy", (N+1)'(busy), (N+1)'(1));
    check("t1_in_ready_low", (N+1)'(bus.in_ready), (N+1)'(0));
    waitResult(lat);
    check("t1_latency", (N+1)'(lat), (N+1)'(WORDS));
    exp = '0;
    exp[64] = 1'b1;
    checkOutput("t1", exp);
    finishHandshake("t1");

    runOp("t2_ripple", all_ones, '0, 1'b1, 1'b0);
    runOp("t3_sub_neg", N'(5), N'(7), 1'b0, 1'b1);
    runOp("t3_sub_pos", N'(7), N'(5), 1'b0, 1'b1);
    runOp("t3_sub_borrow", N'(7), N'(5), 1'b1, 1'b1);

    // Backpressure: result must hold and a new request must be ignored.
    a = rand_wide();
    b = rand_wide();
    applyStimulus(a, b, 1'b1, 1'b0);
    waitResult(lat);
    exp = ref_op(a, b, 1'b1, 1'b0);
    check("t4_latency", (N+1)'(lat), (N+1)'(WORDS));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.in_valid = 1'b1;
        bus.in_a     = rand_wide();
        bus.in_b     = rand_wide();
      end
      if (i == 4) bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("t4_hold", exp);
      check("t4_in_ready_low", (N+1)'(bus.in_ready), (N+1)'(0));
    end
    finishHandshake("t4");
    check("t4_busy_idle", (N+1)'(busy), (N+1)'(0));

    // Reset in the middle of RUN, two slices in.
    applyStimulus(rand_wide(), rand_wide(), 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_busy", (N+1)'(busy), (N+1)'(0));
    check("t5_in_ready", (N+1)'(bus.in_ready), (N+1)'(1));
    check("t5_out", {bus.out_co, bus.out_sum}, '0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    check("t5_no_pulse", (N+1)'(pulses), (N+1)'(0));
    runOp("t5_fresh", N'(3), N'(4), 1'b0, 1'b0);
    check("t5_fresh_value", {bus.out_co, bus.out_sum}, (N+1)'(7));

    // Back-to-back with in_valid and out_ready held high.
    bus.in_a      = N'(1);
    bus.in_b      = N'(1);
    bus.in_ci     = 1'b0;
    bus.in_sub    = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 14; t++) begin
      if (bus.in_valid && bus.in_ready) acc_edges.push_back(t);
      if (bus.out_valid && bus.out_ready) results.push_back({bus.out_co, bus.out_sum});
      @(negedge clk);
      if (acc_edges.size() == 1) begin
        bus.in_a = N'(2);
        bus.in_b = N'(2);
      end
      if (acc_edges.size() >= 2) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    check("t6_accept_count", (N+1)'(acc_edges.size()), (N+1)'(2));
    check("t6_accept_first", (N+1)'(acc_edges.size() > 0 ? acc_edges[0] : -1), (N+1)'(0));
    check("t6_accept_second", (N+1)'(acc_edges.size() > 1 ? acc_edges[1] : -1), (N+1)'(6));
    check("t6_result_count", (N+1)'(results.size()), (N+1)'(2));
    check("t6_result_first", results.size() > 0 ? results[0] : '1, (N+1)'(2));
    check("t6_result_second", results.size() > 1 ? results[1] : '1, (N+1)'(4));

    // Random add/subtract mix.
    for (int i = 0; i < 20; i++) begin
      runOp("rand", rand_wide(), rand_wide(), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
